// File: rtl/banked_reg_file_if.sv
// Bus bundle for banked_reg_file: clear handshake, write port, reservation port and two read ports.
interface banked_reg_file_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NBANKS = 2
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;

    logic              clr_req;
    logic              ready;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              rsv_en;
    logic [BANK_W-1:0] rsv_bank;
    logic [ADDR_W-1:0] rsv_addr;
    logic [BANK_W-1:0] rd1_bank;
    logic [ADDR_W-1:0] rd1_addr;
    logic [WIDTH-1:0]  rd1_data;
    logic              rd1_busy;
    logic [BANK_W-1:0] rd2_bank;
    logic [ADDR_W-1:0] rd2_addr;
    logic [WIDTH-1:0]  rd2_data;
    logic              rd2_busy;

    modport master (
        output clr_req, wr_en, wr_bank, wr_addr, wr_data,
        output rsv_en, rsv_bank, rsv_addr,
        output rd1_bank, rd1_addr, rd2_bank, rd2_addr,
        input  ready, rd1_data, rd1_busy, rd2_data, rd2_busy
    );

    modport slave (
        input  clr_req, wr_en, wr_bank, wr_addr, wr_data,
        input  rsv_en, rsv_bank, rsv_addr,
        input  rd1_bank, rd1_addr, rd2_bank, rd2_addr,
        output ready, rd1_data, rd1_busy, rd2_data, rd2_busy
    );
endinterface

// File: rtl/banked_reg_file.sv
// Multi-bank register file with busy scoreboard and sequential clear engine.
// Define WRITE_BYPASS_EN to forward an in-flight write to matching read ports in the same cycle.
module banked_reg_file #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NBANKS = 2
) (
    input logic             clk,
    input logic             rst_n,
    banked_reg_file_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;

    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] clrPtr_r;
    logic              ready_r;
    logic              active_s;
    logic              wrOk_s;
    logic              rsvOk_s;
    logic [WIDTH-1:0]  rd1Sel_s [NBANKS];
    logic [WIDTH-1:0]  rd2Sel_s [NBANKS];
    logic              rd1BusySel_s [NBANKS];
    logic              rd2BusySel_s [NBANKS];
    logic [WIDTH-1:0]  rd1Or_s;
    logic [WIDTH-1:0]  rd2Or_s;
    logic              rd1BusyOr_s;
    logic              rd2BusyOr_s;

    assign active_s = (state_r == ST_READY);
    assign wrOk_s   = active_s && bus.wr_en  && (bus.wr_addr  != {ADDR_W{1'b0}});
    assign rsvOk_s  = active_s && bus.rsv_en && (bus.rsv_addr != {ADDR_W{1'b0}});

    // Clear sequencer: sweeps clrPtr over every register, then opens the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_CLEAR;
            clrPtr_r <= {ADDR_W{1'b0}};
            ready_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (bus.clr_req) begin
                        clrPtr_r <= {ADDR_W{1'b0}};
                    end else if (clrPtr_r == ADDR_W'(DEPTH - 1)) begin
                        state_r  <= ST_READY;
                        ready_r  <= 1'b1;
                        clrPtr_r <= {ADDR_W{1'b0}};
                    end else begin
                        clrPtr_r <= clrPtr_r + ADDR_W'(1'b1);
                    end
                end
                ST_READY: begin
                    if (bus.clr_req) begin
                        state_r  <= ST_CLEAR;
                        ready_r  <= 1'b0;
                        clrPtr_r <= {ADDR_W{1'b0}};
                    end
                end
                default: begin
                    state_r  <= ST_CLEAR;
                    ready_r  <= 1'b0;
                    clrPtr_r <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [WIDTH-1:0] mem_r [DEPTH];
        logic [DEPTH-1:0] busy_r;
        logic             wrHit_s;
        logic             rsvHit_s;
        logic [WIDTH-1:0] rd1Word_s;
        logic [WIDTH-1:0] rd2Word_s;
        logic             rd1Busy_s;
        logic             rd2Busy_s;

        assign wrHit_s  = wrOk_s  && (bus.wr_bank  == BANK_W'(b));
        assign rsvHit_s = rsvOk_s && (bus.rsv_bank == BANK_W'(b));

        // Array storage: the clear sweep owns the write port until the array is ready.
        always_ff @(posedge clk) begin
            if (!active_s) begin
                mem_r[clrPtr_r] <= {WIDTH{1'b0}};
            end else if (wrHit_s) begin
                mem_r[bus.wr_addr] <= bus.wr_data;
            end
        end

        // Scoreboard: reservation is applied after the write-clear so the newer producer wins.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy_r <= {DEPTH{1'b0}};
            end else if (!active_s || bus.clr_req) begin
                busy_r <= {DEPTH{1'b0}};
            end else begin
                if (wrHit_s) busy_r[bus.wr_addr] <= 1'b0;
                if (rsvHit_s) busy_r[bus.rsv_addr] <= 1'b1;
            end
        end

        // Read port 1 view of this bank.
        always_comb begin
            rd1Word_s = {WIDTH{1'b0}};
            rd1Busy_s = 1'b0;
            if (bus.rd1_bank == BANK_W'(b)) begin
                rd1Word_s = mem_r[bus.rd1_addr];
                rd1Busy_s = busy_r[bus.rd1_addr];
`ifdef WRITE_BYPASS_EN
                if (wrHit_s && (bus.wr_addr == bus.rd1_addr)) begin
                    rd1Word_s = bus.wr_data;
                    rd1Busy_s = rsvHit_s && (bus.rsv_addr == bus.rd1_addr);
                end else begin
                    rd1Word_s = mem_r[bus.rd1_addr];
                end
`endif
            end else begin
                rd1Word_s = {WIDTH{1'b0}};
            end
        end

        // Read port 2 view of this bank.
        always_comb begin
            rd2Word_s = {WIDTH{1'b0}};
            rd2Busy_s = 1'b0;
            if (bus.rd2_bank == BANK_W'(b)) begin
                rd2Word_s = mem_r[bus.rd2_addr];
                rd2Busy_s = busy_r[bus.rd2_addr];
`ifdef WRITE_BYPASS_EN
                if (wrHit_s && (bus.wr_addr == bus.rd2_addr)) begin
                    rd2Word_s = bus.wr_data;
                    rd2Busy_s = rsvHit_s && (bus.rsv_addr == bus.rd2_addr);
                end else begin
                    rd2Word_s = mem_r[bus.rd2_addr];
                end
`endif
            end else begin
                rd2Word_s = {WIDTH{1'b0}};
            end
        end

        assign rd1Sel_s[b]     = rd1Word_s;
        assign rd2Sel_s[b]     = rd2Word_s;
        assign rd1BusySel_s[b] = rd1Busy_s;
        assign rd2BusySel_s[b] = rd2Busy_s;
    end

    // Merge banks; a bank index with no matching bank contributes nothing and reads zero.
    always_comb begin
        rd1Or_s     = {WIDTH{1'b0}};
        rd2Or_s     = {WIDTH{1'b0}};
        rd1BusyOr_s = 1'b0;
        rd2BusyOr_s = 1'b0;
        for (int i = 0; i < NBANKS; i++) begin
            rd1Or_s     = rd1Or_s | rd1Sel_s[i];
            rd2Or_s     = rd2Or_s | rd2Sel_s[i];
            rd1BusyOr_s = rd1BusyOr_s | rd1BusySel_s[i];
            rd2BusyOr_s = rd2BusyOr_s | rd2BusySel_s[i];
        end
    end

    assign bus.ready    = ready_r;
    assign bus.rd1_data = (active_s && (bus.rd1_addr != {ADDR_W{1'b0}})) ? rd1Or_s : {WIDTH{1'b0}};
    assign bus.rd2_data = (active_s && (bus.rd2_addr != {ADDR_W{1'b0}})) ? rd2Or_s : {WIDTH{1'b0}};
    assign bus.rd1_busy = active_s && (bus.rd1_addr != {ADDR_W{1'b0}}) && rd1BusyOr_s;
    assign bus.rd2_busy = active_s && (bus.rd2_addr != {ADDR_W{1'b0}}) && rd2BusyOr_s;
endmodule

// File: tb/tb_banked_reg_file.sv
// Directed testbench for banked_reg_file (default 32x32, two banks).
module tb_banked_reg_file;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int NBANKS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    banked_reg_file_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NBANKS(NBANKS)) bus();

    banked_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NBANKS(NBANKS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.clr_req  = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_bank  = 1'b0;
        bus.wr_addr  = 5'd0;
        bus.wr_data  = 32'h0;
        bus.rsv_en   = 1'b0;
        bus.rsv_bank = 1'b0;
        bus.rsv_addr = 5'd0;
        bus.rd1_bank = 1'b0;
        bus.rd1_addr = 5'd0;
        bus.rd2_bank = 1'b0;
        bus.rd2_addr = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (bus.ready !== 1'b1 && n < 100);
        checks++;
        if (n !== 32) begin errors++; $display("FAIL reset_clear_cycles: got %0d expected 32", n); end
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 32; a++) begin
                bus.rd1_bank = 1'(b); bus.rd1_addr = 5'(a);
                bus.rd2_bank = 1'(b); bus.rd2_addr = 5'(a);
                #1;
                checks++;
                if (bus.rd1_data !== 32'h0 || bus.rd2_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_contents b%0d r%0d: got %h busy %b expected 00000000 busy 0", b, a, bus.rd1_data, bus.rd2_busy);
                end
            end
        end
    endtask

    task automatic test_write_read();
        bus.wr_en = 1'b1; bus.wr_bank = 1'b0; bus.wr_addr = 5'd1; bus.wr_data = 32'd44;
        tick();
        bus.wr_bank = 1'b1; bus.wr_data = 32'hf0f0f0f0;
        tick();
        bus.wr_bank = 1'b0; bus.wr_addr = 5'd2; bus.wr_data = 32'ha5a5a5a5;
        tick();
        bus.wr_en = 1'b0;
        bus.rd1_bank = 1'b0; bus.rd1_addr = 5'd1;
        bus.rd2_bank = 1'b1; bus.rd2_addr = 5'd1;
        #1;
        checks++;
        if (bus.rd1_data !== 32'h0000002c) begin errors++; $display("FAIL wr_b0_r1: got %h expected 0000002c", bus.rd1_data); end
        checks++;
        if (bus.rd2_data !== 32'hf0f0f0f0) begin errors++; $display("FAIL wr_b1_r1: got %h expected f0f0f0f0", bus.rd2_data); end
        bus.rd1_bank = 1'b1; bus.rd1_addr = 5'd2;
        bus.rd2_bank = 1'b0; bus.rd2_addr = 5'd2;
        #1;
        checks++;
        if (bus.rd1_data !== 32'h0) begin errors++; $display("FAIL bank_isolation_b1_r2: got %h expected 00000000", bus.rd1_data); end
        checks++;
        if (bus.rd2_data !== 32'ha5a5a5a5) begin errors++; $display("FAIL wr_b0_r2: got %h expected a5a5a5a5", bus.rd2_data); end
    endtask

    task automatic test_reg_zero();
        bus.wr_en = 1'b1; bus.wr_bank = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'hffffffff;
        tick();
        bus.wr_bank = 1'b1;
        bus.rsv_en = 1'b1; bus.rsv_bank = 1'b0; bus.rsv_addr = 5'd0;
        tick();
        bus.wr_en = 1'b0; bus.rsv_en = 1'b0;
        bus.rd1_bank = 1'b0; bus.rd1_addr = 5'd0;
        bus.rd2_bank = 1'b1; bus.rd2_addr = 5'd0;
        #1;
        checks++;
        if (bus.rd1_data !== 32'h0 || bus.rd1_busy !== 1'b0) begin
            errors++; $display("FAIL r0_bank0: got %h busy %b expected 00000000 busy 0", bus.rd1_data, bus.rd1_busy);
        end
        checks++;
        if (bus.rd2_data !== 32'h0 || bus.rd2_busy !== 1'b0) begin
            errors++; $display("FAIL r0_bank1: got %h busy %b expected 00000000 busy 0", bus.rd2_data, bus.rd2_busy);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        bus.wr_en = 1'b1; bus.wr_bank = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = 32'h12345678;
        tick();
        bus.wr_data = 32'h33333333;
        bus.rd2_bank = 1'b1; bus.rd2_addr = 5'd31;
        #1;
`ifdef WRITE_BYPASS_EN
        exp_same = 32'h33333333;
`else
        exp_same = 32'h12345678;
`endif
        checks++;
        if (bus.rd2_data !== exp_same) begin errors++; $display("FAIL same_cycle_read: got %h expected %h", bus.rd2_data, exp_same); end
        tick();
        bus.wr_en = 1'b0;
        #1;
        checks++;
        if (bus.rd2_data !== 32'h33333333) begin errors++; $display("FAIL next_cycle_read: got %h expected 33333333", bus.rd2_data); end
    endtask

    task automatic test_scoreboard();
        logic exp_busy;
        bus.rd1_bank = 1'b0; bus.rd1_addr = 5'd3;
        bus.rd2_bank = 1'b1; bus.rd2_addr = 5'd3;
        bus.rsv_en = 1'b1; bus.rsv_bank = 1'b0; bus.rsv_addr = 5'd3;
        #1;
        checks++;
        if (bus.rd1_busy !== 1'b0) begin errors++; $display("FAIL busy_before_edge: got %b expected 0", bus.rd1_busy); end
        tick();
        bus.rsv_en = 1'b0;
        #1;
        checks++;
        if (bus.rd1_busy !== 1'b1) begin errors++; $display("FAIL busy_after_rsv: got %b expected 1", bus.rd1_busy); end
        checks++;
        if (bus.rd2_busy !== 1'b0) begin errors++; $display("FAIL busy_other_bank: got %b expected 0", bus.rd2_busy); end
        bus.wr_en = 1'b1; bus.wr_bank = 1'b0; bus.wr_addr = 5'd3; bus.wr_data = 32'h00000077;
        bus.rsv_en = 1'b1;
        #1;
        checks++;
        if (bus.rd1_busy !== 1'b1) begin errors++; $display("FAIL busy_wr_rsv_comb: got %b expected 1", bus.rd1_busy); end
        tick();
        bus.wr_en = 1'b0; bus.rsv_en = 1'b0;
        #1;
        checks++;
        if (bus.rd1_busy !== 1'b1 || bus.rd1_data !== 32'h00000077) begin
            errors++; $display("FAIL busy_wr_rsv_edge: got busy %b data %h expected busy 1 data 00000077", bus.rd1_busy, bus.rd1_data);
        end
        bus.wr_en = 1'b1; bus.wr_data = 32'h00000099;
        #1;
`ifdef WRITE_BYPASS_EN
        exp_busy = 1'b0;
`else
        exp_busy = 1'b1;
`endif
        checks++;
        if (bus.rd1_busy !== exp_busy) begin errors++; $display("FAIL busy_wr_comb: got %b expected %b", bus.rd1_busy, exp_busy); end
        tick();
        bus.wr_en = 1'b0;
        #1;
        checks++;
        if (bus.rd1_busy !== 1'b0 || bus.rd1_data !== 32'h00000099) begin
            errors++; $display("FAIL busy_cleared_by_wr: got busy %b data %h expected busy 0 data 00000099", bus.rd1_busy, bus.rd1_data);
        end
        bus.rsv_en = 1'b1; bus.rsv_bank = 1'b1; bus.rsv_addr = 5'd5;
        tick();
        bus.rsv_en = 1'b0;
        bus.rd2_bank = 1'b1; bus.rd2_addr = 5'd5;
        #1;
        checks++;
        if (bus.rd2_busy !== 1'b1) begin errors++; $display("FAIL busy_b1_r5: got %b expected 1", bus.rd2_busy); end
    endtask

    task automatic test_clear();
        int n;
        bus.rd1_bank = 1'b1; bus.rd1_addr = 5'd31;
        bus.rd2_bank = 1'b1; bus.rd2_addr = 5'd5;
        #1;
        checks++;
        if (bus.rd1_data !== 32'h33333333 || bus.rd2_busy !== 1'b1) begin
            errors++; $display("FAIL clear_precondition: got %h busy %b expected 33333333 busy 1", bus.rd1_data, bus.rd2_busy);
        end
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL clear_ready_drop: got %b expected 0", bus.ready); end
        checks++;
        if (bus.rd1_data !== 32'h0 || bus.rd2_busy !== 1'b0) begin
            errors++; $display("FAIL clear_outputs_gated: got %h busy %b expected 00000000 busy 0", bus.rd1_data, bus.rd2_busy);
        end
        bus.wr_bank = 1'b0; bus.wr_addr = 5'd7; bus.wr_data = 32'hdeadbeef;
        bus.rsv_bank = 1'b0; bus.rsv_addr = 5'd9;
        n = 0;
        do begin
            tick();
            n++;
            bus.wr_en  = (n == 20);
            bus.rsv_en = (n == 20);
        end while (bus.ready !== 1'b1 && n < 100);
        bus.wr_en = 1'b0; bus.rsv_en = 1'b0;
        checks++;
        if (n !== 32) begin errors++; $display("FAIL clear_cycles: got %0d expected 32", n); end
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 32; a++) begin
                bus.rd1_bank = 1'(b); bus.rd1_addr = 5'(a);
                bus.rd2_bank = 1'(b); bus.rd2_addr = 5'(a);
                #1;
                checks++;
                if (bus.rd1_data !== 32'h0 || bus.rd2_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_contents b%0d r%0d: got %h busy %b expected 00000000 busy 0", b, a, bus.rd1_data, bus.rd2_busy);
                end
            end
        end
    endtask

    task automatic test_restart();
        int n;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (10) tick();
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL restart_mid_ready: got %b expected 0", bus.ready); end
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.ready !== 1'b1 && n < 100);
        checks++;
        if (n !== 32) begin errors++; $display("FAIL restart_cycles: got %0d expected 32", n); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reg_zero();
        test_bypass();
        test_scoreboard();
        test_clear();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
